// File: rtl/tlul_pkg.sv
// TL-UL channel types, opcodes and widths shared by the debug host and its bench.
// Latency: n/a (type definitions only).
// Backpressure: n/a; a_ready/d_ready live inside the channel structs.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  // instr_type 4'h9 marks a data (not instruction) access.
  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'h0,
    instr_type: 4'h9,
    cmd_intg:   7'h0,
    data_intg:  7'h0
  };

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    tl_a_user_t          a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    tl_d_user_t          d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tl_dbg_host.sv
// Single-outstanding TL-UL host: turns a cmd handshake into one A request and returns the D result.
// Latency: cmd handshake -> a_valid 1 cycle; matching D beat -> rsp_valid_o 1 cycle; timeout after TimeoutCycles.
// Backpressure: cmd_ready_o only in IDLE; A held until a_ready; d_ready low while a result waits for rsp_ready_i.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_*                   command in (valid/ready): write flag, byte address, data, byte mask
//   rsp_*                   result out (valid/ready): read data, device error, timeout flag
//   tl_h2d_o / tl_d2h_i     TL-UL host/device channels
//   stray_cnt_o             saturating count of accepted D beats that matched no request
module tl_dbg_host
  import tlul_pkg::*;
#(
  parameter int                TimeoutCycles = 1024,
  parameter logic [TL_AIW-1:0] SourceId      = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [TL_AW-1:0]  cmd_addr_i,
  input  logic [TL_DW-1:0]  cmd_wdata_i,
  input  logic [TL_DBW-1:0] cmd_mask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [TL_DW-1:0]  rsp_rdata_o,
  output logic              rsp_error_o,
  output logic              rsp_timeout_o,
  output tl_h2d_t           tl_h2d_o,
  input  tl_d2h_t           tl_d2h_i,
  output logic [7:0]        stray_cnt_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT_D = 2'd2;
  localparam logic [1:0] ST_RSP    = 2'd3;

  localparam logic [31:0] TmoLast = (TimeoutCycles == 0) ? 32'd0 : 32'(TimeoutCycles - 1);

  logic [1:0]        state_q;
  logic              cmd_write_q;
  logic [TL_AW-3:0]  cmd_word_q;
  logic [TL_DW-1:0]  cmd_wdata_q;
  logic [TL_DBW-1:0] cmd_mask_q;
  logic [TL_DW-1:0]  rsp_rdata_q;
  logic              rsp_error_q;
  logic              rsp_timeout_q;
  logic [7:0]        stray_cnt_q;
  logic [31:0]       tmo_cnt_q;

  logic     a_hs;
  logic     d_acc;
  logic     d_match;
  logic     d_stray;
  logic     tmo_hit;
  logic     busy;
  tl_a_op_e a_opcode;

  assign busy  = (state_q == ST_REQ) || (state_q == ST_WAIT_D);
  assign a_hs  = (state_q == ST_REQ) && tl_d2h_i.a_ready;
  // Every D beat offered while d_ready is high is consumed, wanted or not.
  assign d_acc = tl_d2h_i.d_valid && (state_q != ST_RSP);
  // A beat can only belong to our request once the A side has been accepted,
  // which includes the cycle of the A handshake itself.
  assign d_match = d_acc && (tl_d2h_i.d_source == SourceId) &&
                   ((state_q == ST_WAIT_D) || a_hs);
  assign d_stray = d_acc && !d_match;
  assign tmo_hit = (TimeoutCycles != 0) && busy && (tmo_cnt_q == TmoLast) && !d_match;

  always_comb begin
    a_opcode = Get;
    if (cmd_write_q) begin
      a_opcode = (cmd_mask_q == {TL_DBW{1'b1}}) ? PutFullData : PutPartialData;
    end
  end

  always_comb begin
    tl_h2d_o           = '0;
    tl_h2d_o.a_valid   = (state_q == ST_REQ);
    tl_h2d_o.a_opcode  = a_opcode;
    tl_h2d_o.a_param   = 3'd0;
    tl_h2d_o.a_size    = TL_SZW'(2);
    tl_h2d_o.a_source  = SourceId;
    tl_h2d_o.a_address = {cmd_word_q, 2'b00};
    tl_h2d_o.a_mask    = cmd_write_q ? cmd_mask_q : {TL_DBW{1'b1}};
    tl_h2d_o.a_data    = cmd_write_q ? cmd_wdata_q : '0;
    tl_h2d_o.a_user    = TL_A_USER_DEFAULT;
    tl_h2d_o.d_ready   = (state_q != ST_RSP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cmd_write_q   <= 1'b0;
      cmd_word_q    <= '0;
      cmd_wdata_q   <= '0;
      cmd_mask_q    <= '0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      stray_cnt_q   <= 8'd0;
      tmo_cnt_q     <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            cmd_write_q <= cmd_write_i;
            cmd_word_q  <= cmd_addr_i[TL_AW-1:2];
            cmd_wdata_q <= cmd_wdata_i;
            cmd_mask_q  <= cmd_mask_i;
            tmo_cnt_q   <= 32'd0;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT_D: begin
          tmo_cnt_q <= tmo_cnt_q + 32'd1;
          // Completion wins over a timeout landing in the same cycle.
          if (d_match) begin
            rsp_error_q   <= tl_d2h_i.d_error;
            rsp_rdata_q   <= cmd_write_q ? '0 : tl_d2h_i.d_data;
            rsp_timeout_q <= 1'b0;
            state_q       <= ST_RSP;
          end else if (tmo_hit) begin
            rsp_error_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            state_q       <= ST_RSP;
          end else if (a_hs) begin
            state_q <= ST_WAIT_D;
          end
        end
        ST_RSP: begin
          if (rsp_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (d_stray && (stray_cnt_q != 8'hFF)) begin
        stray_cnt_q <= stray_cnt_q + 8'd1;
      end
    end
  end

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign rsp_valid_o   = (state_q == ST_RSP);
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_error_o   = rsp_error_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign stray_cnt_o   = stray_cnt_q;

  logic unused_d2h;
  assign unused_d2h = ^{tl_d2h_i.d_opcode, tl_d2h_i.d_param, tl_d2h_i.d_size,
                        tl_d2h_i.d_sink, tl_d2h_i.d_user, cmd_addr_i[1:0]};

endmodule

// File: tb/tb_tl_dbg_host.sv
// Bench for tl_dbg_host: directed scenarios plus randomized transactions against a timing model.
// Latency: n/a.
// Backpressure: device a_ready/d_valid and rsp_ready are scheduled per transaction.
module tb_tl_dbg_host;
  import tlul_pkg::*;

  localparam int          TMO = 8;
  localparam logic [7:0]  SRC = 8'h03;

  logic              clk;
  logic              rst_i;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [31:0]       cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic              rsp_timeout;
  tl_h2d_t           h2d;
  tl_d2h_t           d2h;
  logic [7:0]        stray_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_stray = 0;

  tl_dbg_host #(.TimeoutCycles(TMO), .SourceId(SRC)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_mask_i   (cmd_mask),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_error_o  (rsp_error),
    .rsp_timeout_o(rsp_timeout),
    .tl_h2d_o     (h2d),
    .tl_d2h_i     (d2h),
    .stray_cnt_o  (stray_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void bump_stray();
    if (exp_stray < 255) exp_stray++;
  endfunction

  // One transaction. Cycle k counts from the first cycle the request is on the
  // A channel. a_dly: cycles before a_ready; d_dly: cycles from A acceptance to
  // the response beat (0 = same cycle). The request finishes at k = a_dly+d_dly
  // unless that is at or beyond the timeout window, in which case it gives up at
  // k = TMO-1. stray_k (<0 = none) injects an unrelated D beat before the end.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input int a_dly, input int d_dly,
                        input logic derr, input logic [31:0] ddata, input int stray_k,
                        input logic stray_same_src, input int rsp_dly);
    bit          tmo;
    int          e;
    int          a_last;
    logic [2:0]  exp_op;
    logic [31:0] exp_rdata;
    logic        exp_err;
    tmo    = (a_dly + d_dly >= TMO);
    e      = tmo ? TMO - 1 : a_dly + d_dly;
    a_last = (a_dly < e) ? a_dly : e;
    exp_op = !wr ? 3'h4 : ((mask == 4'hF) ? 3'h0 : 3'h1);

    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_mask  = mask;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_mask  = 4'($urandom);

    for (int k = 0; k <= e; k++) begin
      chk("a_valid", 64'(h2d.a_valid), 64'(k <= a_last));
      if (k <= a_last) begin
        chk("a_address", 64'(h2d.a_address), 64'({addr[31:2], 2'b00}));
        chk("a_opcode", 64'(h2d.a_opcode), 64'(exp_op));
        chk("a_mask", 64'(h2d.a_mask), 64'(wr ? mask : 4'hF));
        chk("a_data", 64'(h2d.a_data), 64'(wr ? wdata : 32'h0));
        chk("a_size", 64'(h2d.a_size), 64'(2));
        chk("a_source", 64'(h2d.a_source), 64'(SRC));
        chk("a_param", 64'(h2d.a_param), 64'(0));
        chk("a_user", 64'(h2d.a_user), 64'(TL_A_USER_DEFAULT));
      end
      chk("rsp_valid_busy", 64'(rsp_valid), 64'(0));
      chk("d_ready_busy", 64'(h2d.d_ready), 64'(1));
      d2h.a_ready = (k == a_dly);
      d2h.d_valid = 1'b0;
      if (!tmo && (k == a_dly + d_dly)) begin
        d2h.d_valid  = 1'b1;
        d2h.d_source = SRC;
        d2h.d_data   = ddata;
        d2h.d_error  = derr;
        d2h.d_opcode = wr ? AccessAck : AccessAckData;
      end else if ((k == stray_k) && (k < e)) begin
        d2h.d_valid  = 1'b1;
        d2h.d_source = (stray_same_src && (k < a_dly)) ? SRC : SRC + 8'd1;
        d2h.d_data   = $urandom;
        d2h.d_error  = 1'($urandom);
        bump_stray();
      end
      @(negedge clk);
    end
    d2h.a_ready = 1'b0;
    d2h.d_valid = 1'b0;

    exp_rdata = tmo ? 32'h0 : (wr ? 32'h0 : ddata);
    exp_err   = tmo ? 1'b1 : derr;
    for (int w = 0; w <= rsp_dly; w++) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(1));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      chk("rsp_error", 64'(rsp_error), 64'(exp_err));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(tmo));
      chk("a_valid_rsp", 64'(h2d.a_valid), 64'(0));
      chk("d_ready_rsp", 64'(h2d.d_ready), 64'(0));
      chk("stray_cnt", 64'(stray_cnt), 64'(exp_stray));
      if (w == rsp_dly) begin
        rsp_ready = 1'b1;
      end else if (w == 0) begin
        // Offered while d_ready is low: must be neither taken nor counted.
        d2h.d_valid  = 1'b1;
        d2h.d_source = SRC + 8'd2;
      end
      @(negedge clk);
      d2h.d_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    chk("rsp_valid_done", 64'(rsp_valid), 64'(0));
    chk("cmd_ready_done", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    rst_i     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_mask  = '0;
    rsp_ready = 1'b0;
    d2h       = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_a_valid", 64'(h2d.a_valid), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_error", 64'(rsp_error), 64'(0));
    chk("rst_timeout", 64'(rsp_timeout), 64'(0));
    chk("rst_stray", 64'(stray_cnt), 64'(0));
    chk("rst_d_ready", 64'(h2d.d_ready), 64'(1));
    rst_i = 1'b0;
    @(negedge clk);

    // Full-word write to an unaligned address.
    do_txn(1'b1, 32'h0000_1003, 32'hA5A5_A5A5, 4'hF, 0, 1, 1'b0, 32'h1111_2222, -1, 1'b0, 0);
    // Read answered three cycles after acceptance.
    do_txn(1'b0, 32'h0000_2000, 32'h0, 4'h0, 0, 3, 1'b0, 32'hDEAD_BEEF, -1, 1'b0, 0);
    // Partial write with a device error.
    do_txn(1'b1, 32'h0000_3004, 32'h1234_5678, 4'h3, 1, 1, 1'b1, 32'h0, -1, 1'b0, 1);
    // A channel never accepted: times out after TMO cycles of a_valid.
    do_txn(1'b0, 32'h0000_4000, 32'h0, 4'hF, 40, 0, 1'b0, 32'h0, -1, 1'b0, 0);
    // Wrong-source beat while waiting, then the real response.
    do_txn(1'b0, 32'h0000_5008, 32'h0, 4'hF, 0, 3, 1'b0, 32'hCAFE_F00D, 1, 1'b0, 0);
    // Right-source beat before the A handshake is still unrelated.
    do_txn(1'b0, 32'h0000_500C, 32'h0, 4'hF, 3, 1, 1'b0, 32'h0BAD_F00D, 1, 1'b1, 0);
    // Response in the same cycle as A acceptance; result held for 5 cycles.
    do_txn(1'b0, 32'h0000_6000, 32'h0, 4'hF, 2, 0, 1'b1, 32'h5555_AAAA, -1, 1'b0, 5);
    // Completion on the last cycle of the window beats the timeout.
    do_txn(1'b0, 32'h0000_7000, 32'h0, 4'hF, 3, TMO - 4, 1'b0, 32'h7777_0001, -1, 1'b0, 0);
    // One cycle later and it times out after A was accepted.
    do_txn(1'b1, 32'h0000_7004, 32'hFFFF_0000, 4'hC, 3, TMO - 3, 1'b0, 32'h0, -1, 1'b0, 0);

    // Reset while waiting for D; the late beat is then counted as stray.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_8000;
    @(negedge clk);
    cmd_valid   = 1'b0;
    d2h.a_ready = 1'b1;
    @(negedge clk);
    d2h.a_ready = 1'b0;
    chk("wait_a_valid", 64'(h2d.a_valid), 64'(0));
    chk("wait_cmd_ready", 64'(cmd_ready), 64'(0));
    rst_i = 1'b1;
    @(negedge clk);
    rst_i     = 1'b0;
    exp_stray = 0;
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_mid_stray", 64'(stray_cnt), 64'(0));
    d2h.d_valid  = 1'b1;
    d2h.d_source = SRC;
    d2h.d_data   = 32'h9999_9999;
    @(negedge clk);
    d2h.d_valid = 1'b0;
    bump_stray();
    chk("late_beat_stray", 64'(stray_cnt), 64'(exp_stray));
    chk("late_beat_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("late_beat_cmd_ready", 64'(cmd_ready), 64'(1));

    for (int t = 0; t < 40; t++) begin
      int   a;
      int   d;
      int   e;
      int   sk;
      logic wr;
      logic [3:0] m;
      a  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 4));
      d  = int'($urandom_range(0, 5));
      e  = (a + d >= TMO) ? TMO - 1 : a + d;
      sk = (($urandom_range(0, 2) == 0) && (e > 0)) ? int'($urandom_range(0, e - 1)) : -1;
      wr = 1'($urandom);
      m  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      do_txn(wr, $urandom, $urandom, m, a, d, 1'($urandom), $urandom, sk, 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
